ysyx_rob: RTL and testbench

YSYX_ROB -- requirements
Module: ysyx_rob

---
 rtl/ysyx_rob_pkg.sv | 28 ++
 rtl/ysyx_rob_rat.sv | 46 ++++
 rtl/ysyx_rob.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_rob.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_rob_pkg.sv
// Shared ysyx definitions for the reorder buffer: default sizes, the tag encoding
// and the per-entry payload record.
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 4
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_rob_pkg;

    localparam int ROB_SIZE_DEF = `YSYX_ROB_SIZE;
    localparam int XLEN_DEF     = `YSYX_XLEN;

    // Tags are entry index + 1, so one extra bit leaves room for the "no producer" value.
    localparam int               TAG_W    = $clog2(ROB_SIZE_DEF) + 1;
    localparam logic [TAG_W-1:0] TAG_NONE = '0;

    typedef struct packed {
        logic [4:0]          rd;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pnpc;
        logic [XLEN_DEF-1:0] npc;
        logic [XLEN_DEF-1:0] result;
        logic [31:0]         inst;
    } rob_entry_t;

endpackage

// File: rtl/ysyx_rob_rat.sv
// Register alias table: maps each architectural register to the ROB tag of its
// youngest in-flight producer, or TAG_NONE when the register file holds the value.
module ysyx_rob_rat
    import ysyx_rob_pkg::*;
#(
    parameter int TW = TAG_W
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [4:0]    rs1,
    input  logic [4:0]    rs2,
    output logic [TW-1:0] q1,
    output logic [TW-1:0] q2,
    input  logic          set_en,
    input  logic [4:0]    set_rd,
    input  logic [TW-1:0] set_tag,
    input  logic          clr_en,
    input  logic [4:0]    clr_rd,
    input  logic [TW-1:0] clr_tag,
    input  logic          flush
);

    logic [TW-1:0] rat [32];

    assign q1 = rat[rs1];
    assign q2 = rat[rs2];

    // NOTE: the table must read as empty the moment reset asserts, so every slot is
    // in the async reset; state updates use <= so all slots see the same pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) rat[i] <= TW'(TAG_NONE);
        end else if (flush) begin
            for (int i = 0; i < 32; i++) rat[i] <= TW'(TAG_NONE);
        end else begin
            // x0 never gets a producer; a same-cycle rename beats the retire clear.
            for (int i = 1; i < 32; i++) begin
                if (set_en && set_rd == 5'(i))
                    rat[i] <= set_tag;
                else if (clr_en && clr_rd == 5'(i) && rat[i] == clr_tag)
                    rat[i] <= TW'(TAG_NONE);
            end
        end
    end

endmodule

// File: rtl/ysyx_rob.sv
// Reorder buffer: in-order dispatch with renaming and operand forwarding,
// out-of-order writeback, in-order retire with misprediction flush.
`ifndef YSYX_ROB_SIZE
`define YSYX_ROB_SIZE 4
`endif
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

module ysyx_rob
    import ysyx_rob_pkg::*;
#(
    parameter  int ROB_SIZE = `YSYX_ROB_SIZE,
    parameter  int XLEN     = `YSYX_XLEN,
    localparam int TW       = $clog2(ROB_SIZE) + 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            disp_valid,
    output logic            disp_ready,
    input  logic [4:0]      disp_rd,
    input  logic [XLEN-1:0] disp_pc,
    input  logic [XLEN-1:0] disp_pnpc,
    input  logic [31:0]     disp_inst,
    input  logic [4:0]      disp_rs1,
    input  logic [4:0]      disp_rs2,
    output logic [TW-1:0]   disp_dest,
    output logic [TW-1:0]   disp_qj,
    output logic [TW-1:0]   disp_qk,
    output logic [XLEN-1:0] disp_vj,
    output logic [XLEN-1:0] disp_vk,
    output logic            disp_fj,
    output logic            disp_fk,
    input  logic            wb_valid,
    input  logic [TW-1:0]   wb_dest,
    input  logic [XLEN-1:0] wb_result,
    input  logic [XLEN-1:0] wb_npc,
    output logic            cm_valid,
    output logic [4:0]      cm_rd,
    output logic [XLEN-1:0] cm_result,
    output logic [XLEN-1:0] cm_pc,
    output logic [31:0]     cm_inst,
    output logic            flush,
    output logic [XLEN-1:0] flush_npc
);

    localparam int IW = TW - 1;

    logic [IW-1:0]       head, tail;
    logic [TW-1:0]       count;
    logic [ROB_SIZE-1:0] ent_valid, ent_done;
    rob_entry_t          ent [ROB_SIZE];
    rob_entry_t          head_ent;

    logic          retire, mispredict, can_disp, disp_fire, wb_ok;
    logic [IW-1:0] wb_idx;
    logic [TW-1:0] head_tag;
    logic [TW-1:0] rat_q  [2];
    logic [IW-1:0] src_idx [2];
    logic [TW-1:0] op_q   [2];
    logic          op_f   [2];
    logic [XLEN-1:0] op_v [2];

    assign head_ent   = ent[head];
    assign head_tag   = {1'b0, head} + TW'(1);
    assign retire     = ent_valid[head] & ent_done[head];
    assign mispredict = retire & (head_ent.npc != head_ent.pnpc);
    // A full ROB stays closed even while retiring: the freed slot is reused next cycle.
    assign can_disp   = (count < TW'(ROB_SIZE)) & ~mispredict;
    assign disp_fire  = disp_valid & can_disp;

    assign wb_idx = wb_dest[IW-1:0] - IW'(1);
    assign wb_ok  = wb_valid & (wb_dest != TW'(TAG_NONE)) & (wb_dest <= TW'(ROB_SIZE))
                  & ent_valid[wb_idx];

    ysyx_rob_rat #(.TW(TW)) u_rat (
        .clock   (clock),
        .reset   (reset),
        .rs1     (disp_rs1),
        .rs2     (disp_rs2),
        .q1      (rat_q[0]),
        .q2      (rat_q[1]),
        .set_en  (disp_fire && disp_rd != 5'd0),
        .set_rd  (disp_rd),
        .set_tag (disp_dest),
        .clr_en  (retire),
        .clr_rd  (head_ent.rd),
        .clr_tag (head_tag),
        .flush   (mispredict)
    );

    // NOTE: every variable written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            op_q[k]    = TW'(TAG_NONE);
            op_f[k]    = 1'b0;
            op_v[k]    = '0;
            src_idx[k] = rat_q[k][IW-1:0] - IW'(1);
            if (rat_q[k] != TW'(TAG_NONE)) begin
                if (ent_done[src_idx[k]]) begin
                    op_f[k] = 1'b1;
                    op_v[k] = ent[src_idx[k]].result;
                end else if (wb_valid && wb_dest == rat_q[k]) begin
                    op_f[k] = 1'b1;
                    op_v[k] = wb_result;
                end else begin
                    op_q[k] = rat_q[k];
                end
            end
        end
    end

    // Entry state already clears asynchronously; only the free-slot view needs masking in reset.
    assign disp_ready = reset & can_disp;
    assign disp_dest  = reset ? ({1'b0, tail} + TW'(1)) : '0;
    assign disp_qj    = op_q[0];
    assign disp_qk    = op_q[1];
    assign disp_fj    = op_f[0];
    assign disp_fk    = op_f[1];
    assign disp_vj    = op_v[0];
    assign disp_vk    = op_v[1];

    assign cm_valid  = retire;
    assign cm_rd     = retire ? head_ent.rd     : '0;
    assign cm_result = retire ? head_ent.result : '0;
    assign cm_pc     = retire ? head_ent.pc     : '0;
    assign cm_inst   = retire ? head_ent.inst   : '0;
    assign flush     = mispredict;
    assign flush_npc = mispredict ? head_ent.npc : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else if (mispredict) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            if (wb_ok) ent_done[wb_idx] <= 1'b1;
            if (retire) begin
                ent_valid[head] <= 1'b0;
                ent_done[head]  <= 1'b0;
                head            <= head + IW'(1);
            end
            if (disp_fire) begin
                ent_valid[tail] <= 1'b1;
                ent_done[tail]  <= 1'b0;
                tail            <= tail + IW'(1);
            end
            case ({disp_fire, retire})
                2'b10:   count <= count + TW'(1);
                2'b01:   count <= count - TW'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: the payload is only read behind valid/done, so it carries no reset and
    // can map onto plain storage.
    always_ff @(posedge clock) begin
        if (disp_fire) begin
            ent[tail].rd   <= disp_rd;
            ent[tail].pc   <= disp_pc;
            ent[tail].pnpc <= disp_pnpc;
            ent[tail].inst <= disp_inst;
        end
        if (wb_ok) begin
            ent[wb_idx].result <= wb_result;
            ent[wb_idx].npc    <= wb_npc;
        end
    end

endmodule

// File: tb/tb_ysyx_rob.sv
// Scoreboard bench for ysyx_rob: a tag-indexed reference model predicts lookups and
// retirements; a negedge monitor pops expected commits and compares them.
module tb_ysyx_rob;

    localparam int ROB_SIZE = 4;
    localparam int XLEN     = 32;
    localparam int TW       = $clog2(ROB_SIZE) + 1;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            disp_valid, disp_ready;
    logic [4:0]      disp_rd, disp_rs1, disp_rs2;
    logic [XLEN-1:0] disp_pc, disp_pnpc;
    logic [31:0]     disp_inst;
    logic [TW-1:0]   disp_dest, disp_qj, disp_qk;
    logic [XLEN-1:0] disp_vj, disp_vk;
    logic            disp_fj, disp_fk;
    logic            wb_valid;
    logic [TW-1:0]   wb_dest;
    logic [XLEN-1:0] wb_result, wb_npc;
    logic            cm_valid;
    logic [4:0]      cm_rd;
    logic [XLEN-1:0] cm_result, cm_pc;
    logic [31:0]     cm_inst;
    logic            flush;
    logic [XLEN-1:0] flush_npc;

    always #5 clock = ~clock;

    ysyx_rob #(.ROB_SIZE(ROB_SIZE), .XLEN(XLEN)) dut (
        .clock(clock), .reset(reset),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
        .disp_pc(disp_pc), .disp_pnpc(disp_pnpc), .disp_inst(disp_inst),
        .disp_rs1(disp_rs1), .disp_rs2(disp_rs2), .disp_dest(disp_dest),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_fj(disp_fj), .disp_fk(disp_fk),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_result(wb_result), .wb_npc(wb_npc),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_result(cm_result), .cm_pc(cm_pc),
        .cm_inst(cm_inst), .flush(flush), .flush_npc(flush_npc)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: instructions indexed by tag, program order kept in a queue.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] pc, pnpc, inst, result, npc;
        bit          valid, done;
    } m_ent_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] result, pc, inst, flush_npc;
        bit          flush;
    } commit_t;

    m_ent_t      m [1:ROB_SIZE];
    int unsigned m_order [$];
    int unsigned m_rat [32];
    int unsigned m_next_tag;
    commit_t     sb [$];

    logic            obs_ready, obs_fj, obs_flush;
    logic [TW-1:0]   obs_dest, obs_qj, obs_qk;
    logic [XLEN-1:0] obs_vj, obs_flush_npc;

    task automatic model_reset();
        for (int t = 1; t <= ROB_SIZE; t++) begin
            m[t].valid = 1'b0;
            m[t].done  = 1'b0;
        end
        m_order.delete();
        for (int r = 0; r < 32; r++) m_rat[r] = 0;
        m_next_tag = 1;
    endtask

    task automatic exp_lookup(input logic [4:0] rs, input bit wv, input int unsigned wd,
                              input logic [31:0] wr, output int unsigned q, output bit f,
                              output logic [31:0] v);
        int unsigned p;
        p = m_rat[rs];
        q = 0; f = 1'b0; v = '0;
        if (p != 0) begin
            if (m[p].done) begin
                f = 1'b1; v = m[p].result;
            end else if (wv && wd == p) begin
                f = 1'b1; v = wr;
            end else begin
                q = p;
            end
        end
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0; disp_rd = '0; disp_pc = '0; disp_pnpc = '0; disp_inst = '0;
        disp_rs1 = '0; disp_rs2 = '0;
        wb_valid = 1'b0; wb_dest = '0; wb_result = '0; wb_npc = '0;
    endtask

    // One clock: drive at posedge+1, check combinational outputs, predict any retire,
    // then update the model at the edge.
    task automatic cycle(input bit dv, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input bit wv,
                         input int unsigned wd, input logic [31:0] wr, input logic [31:0] wn);
        bit ret, fl, ready, fire, f;
        int unsigned h, q, t;
        logic [31:0] v;
        disp_valid = dv; disp_rd = rd; disp_pc = pc; disp_pnpc = pc + 32'd4;
        disp_inst = $urandom; disp_rs1 = rs1; disp_rs2 = rs2;
        wb_valid = wv; wb_dest = TW'(wd); wb_result = wr; wb_npc = wn;
        #3;
        ret   = m_order.size() > 0 && m[m_order[0]].done;
        h     = ret ? m_order[0] : 0;
        fl    = ret && (m[h].npc != m[h].pnpc);
        ready = (m_order.size() < ROB_SIZE) && !fl;
        fire  = dv && ready;
        check("disp_ready", disp_ready, ready);
        check("disp_dest", disp_dest, m_next_tag);
        exp_lookup(rs1, wv, wd, wr, q, f, v);
        check("disp_qj", disp_qj, q);
        check("disp_fj", disp_fj, f);
        if (f || q == 0) check("disp_vj", disp_vj, v);
        exp_lookup(rs2, wv, wd, wr, q, f, v);
        check("disp_qk", disp_qk, q);
        check("disp_fk", disp_fk, f);
        if (f || q == 0) check("disp_vk", disp_vk, v);
        obs_ready = disp_ready; obs_dest = disp_dest; obs_qj = disp_qj; obs_qk = disp_qk;
        obs_fj = disp_fj; obs_vj = disp_vj; obs_flush = flush; obs_flush_npc = flush_npc;
        if (ret) sb.push_back('{rd: m[h].rd, result: m[h].result, pc: m[h].pc, inst: m[h].inst,
                                flush_npc: fl ? m[h].npc : 32'd0, flush: fl});
        @(posedge clock);
        if (fl) begin
            model_reset();
        end else begin
            if (wv && wd >= 1 && wd <= ROB_SIZE && m[wd].valid) begin
                m[wd].done = 1'b1; m[wd].result = wr; m[wd].npc = wn;
            end
            if (ret) begin
                void'(m_order.pop_front());
                m[h].valid = 1'b0; m[h].done = 1'b0;
                if (m_rat[m[h].rd] == h && !(fire && rd == m[h].rd)) m_rat[m[h].rd] = 0;
            end
            if (fire) begin
                t = m_next_tag;
                m[t].rd = rd; m[t].pc = pc; m[t].pnpc = pc + 32'd4; m[t].inst = disp_inst;
                m[t].valid = 1'b1; m[t].done = 1'b0;
                m_order.push_back(t);
                if (rd != 0) m_rat[rd] = t;
                m_next_tag = t % ROB_SIZE + 1;
            end
        end
        #1;
        idle_inputs();
    endtask

    // Monitor: every retirement must match the oldest expected commit, in the same cycle.
    always @(negedge clock) begin : monitor
        commit_t e;
        if (!reset) begin
            check("reset_cm_valid", cm_valid, 1'b0);
            check("reset_flush", flush, 1'b0);
        end else if (cm_valid || sb.size() > 0) begin
            if (sb.size() == 0) begin
                check("unexpected_retire", cm_valid, 1'b0);
            end else begin
                e = sb.pop_front();
                check("cm_valid", cm_valid, 1'b1);
                check("cm_rd", cm_rd, e.rd);
                check("cm_result", cm_result, e.result);
                check("cm_pc", cm_pc, e.pc);
                check("cm_inst", cm_inst, e.inst);
                check("flush", flush, e.flush);
                check("flush_npc", flush_npc, e.flush_npc);
            end
        end
    end

    initial begin
        int unsigned pend [$];
        int unsigned wd;
        bit wv;
        logic [31:0] wn;
        idle_inputs();
        disp_rs1 = 5'd5;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_disp_ready", disp_ready, 1'b0);
        check("reset_disp_dest", disp_dest, '0);
        check("reset_disp_qj", disp_qj, '0);
        check("reset_flush_npc", flush_npc, '0);
        disp_rs1 = '0;
        reset = 1'b1;

        // First dispatch gets tag 1; a following lookup of its rd waits on it.
        cycle(1, 5'd5, 32'h100, 5'd0, 5'd0, 0, 0, 0, 0);
        check("first_dest", obs_dest, 1);
        cycle(1, 5'd7, 32'h104, 5'd5, 5'd0, 0, 0, 0, 0);
        check("lookup_qj", obs_qj, 1);
        check("lookup_fj", obs_fj, 1'b0);
        cycle(1, 5'd8, 32'h108, 5'd0, 5'd0, 0, 0, 0, 0);
        cycle(1, 5'd9, 32'h10c, 5'd0, 5'd0, 0, 0, 0, 0);

        // Full: no acceptance, not even while the head retires; wrap to tag 1 afterwards.
        cycle(1, 5'd10, 32'h110, 5'd0, 5'd0, 1, 1, 32'h111, m[1].pnpc);
        check("full_ready", obs_ready, 1'b0);
        cycle(1, 5'd10, 32'h110, 5'd0, 5'd0, 0, 0, 0, 0);
        check("full_retire_ready", obs_ready, 1'b0);
        cycle(1, 5'd3, 32'h114, 5'd0, 5'd0, 0, 0, 0, 0);
        check("wrap_ready", obs_ready, 1'b1);
        check("wrap_dest", obs_dest, 1);

        // Same-cycle writeback bypass into the lookup.
        cycle(0, 5'd0, 32'h0, 5'd8, 5'd0, 1, 3, 32'hDEAD, m[3].pnpc);
        check("bypass_qj", obs_qj, 0);
        check("bypass_fj", obs_fj, 1'b1);
        check("bypass_vj", obs_vj, 32'hDEAD);

        // Out-of-order writeback, in-order retire of tags 2,3,4.
        cycle(0, 5'd0, 32'h0, 5'd9, 5'd7, 1, 4, 32'h444, m[4].pnpc);
        cycle(0, 5'd0, 32'h0, 5'd9, 5'd7, 1, 2, 32'h222, m[2].pnpc);
        repeat (3) cycle(0, 5'd0, 32'h0, 5'd9, 5'd8, 0, 0, 0, 0);

        // Misprediction: flush at retire, dispatch in that cycle dropped, RAT emptied.
        cycle(1, 5'd11, 32'h80000000, 5'd0, 5'd0, 0, 0, 0, 0);
        cycle(0, 5'd0, 32'h0, 5'd11, 5'd3, 1, 1, 32'h1234, m[1].pnpc);
        cycle(0, 5'd0, 32'h0, 5'd11, 5'd0, 1, 2, 32'h5678, 32'h80000100);
        cycle(1, 5'd12, 32'h200, 5'd11, 5'd3, 0, 0, 0, 0);
        check("mispredict_flush", obs_flush, 1'b1);
        check("mispredict_npc", obs_flush_npc, 32'h80000100);
        check("mispredict_ready", obs_ready, 1'b0);
        cycle(0, 5'd0, 32'h0, 5'd11, 5'd3, 0, 0, 0, 0);
        check("post_flush_qj", obs_qj, 0);
        check("post_flush_qk", obs_qk, 0);
        check("post_flush_dest", obs_dest, 1);

        // Reset in flight with a retire-ready head: nothing retires.
        cycle(1, 5'd1, 32'h300, 5'd0, 5'd0, 0, 0, 0, 0);
        cycle(1, 5'd2, 32'h304, 5'd0, 5'd0, 0, 0, 0, 0);
        cycle(1, 5'd3, 32'h308, 5'd0, 5'd0, 0, 0, 0, 0);
        cycle(0, 5'd0, 32'h0, 5'd0, 5'd0, 1, 1, 32'h99, m[1].pnpc);
        reset = 1'b0;
        #1;
        check("midrst_cm_valid", cm_valid, 1'b0);
        check("midrst_ready", disp_ready, 1'b0);
        check("midrst_dest", disp_dest, '0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        cycle(1, 5'd4, 32'h400, 5'd1, 5'd2, 0, 0, 0, 0);
        check("after_reset_dest", obs_dest, 1);

        // Randomized traffic over a small register set to provoke RAT hits.
        for (int n = 0; n < 800; n++) begin
            pend.delete();
            foreach (m_order[i]) if (!m[m_order[i]].done) pend.push_back(m_order[i]);
            wv = 1'b0; wd = 0; wn = '0;
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                wv = 1'b1;
                wd = pend[$urandom_range(0, pend.size() - 1)];
            end else if ($urandom_range(0, 5) == 0) begin
                wd = $urandom_range(0, (1 << TW) - 1);
                wv = !(wd >= 1 && wd <= ROB_SIZE && m[wd].valid && m[wd].done);
            end
            if (wv && wd >= 1 && wd <= ROB_SIZE)
                wn = ($urandom_range(0, 19) == 0) ? $urandom : m[wd].pnpc;
            cycle($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), wv, wd, $urandom, wn);
        end

        // Drain: write back everything still pending, then let it retire.
        for (int n = 0; n < 4 * ROB_SIZE && m_order.size() > 0; n++) begin
            pend.delete();
            foreach (m_order[i]) if (!m[m_order[i]].done) pend.push_back(m_order[i]);
            if (pend.size() > 0)
                cycle(0, 5'd0, 32'h0, 5'd0, 5'd0, 1, pend[0], $urandom, m[pend[0]].pnpc);
            else
                cycle(0, 5'd0, 32'h0, 5'd0, 5'd0, 0, 0, 0, 0);
        end
        check("model_drained", 64'(m_order.size()), 0);
        @(negedge clock);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
